// File: rtl/pa_rtu_fgpr_wb_pkg.sv
// Shared FPU/RTU definitions for the FGPR writeback path.
// Register-number widths, the writeback entry and a one-hot helper.
package pa_rtu_fgpr_wb_pkg;

    localparam int FREG_W   = 5;
    localparam int FGPR_NUM = 32;
    localparam int FLEN_DEF = 32;

    typedef logic [FREG_W-1:0] freg_t;

    typedef struct packed {
        freg_t               rd;
        logic [FLEN_DEF-1:0] data;
    } fgpr_wb_t;

    function automatic logic [FGPR_NUM-1:0] reg_onehot(input freg_t r);
        logic [FGPR_NUM-1:0] v;
        v    = '0;
        v[r] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/pa_rtu_fgpr_wb_fifo.sv
// In-order buffer for FPU results waiting on the FGPR write port.
// Exposes per-entry valid/register so the owner can build a pending mask.
module pa_rtu_fgpr_wb_fifo
    import pa_rtu_fgpr_wb_pkg::*;
#(
    parameter int W     = 37,
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [W-1:0]                   push_data,
    input  logic                           pop,
    output logic [W-1:0]                   head,
    output logic [PW-1:0]                  head_idx,
    output logic [CW-1:0]                  count,
    output logic [DEPTH-1:0]               ent_vld,
    output logic [DEPTH-1:0][FREG_W-1:0]   ent_reg
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           rptr;
    logic [PW-1:0]           wptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head     = mem[rptr];
    assign head_idx = rptr;

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off        = PW'(i) - rptr;
            ent_vld[i] = (CW'(off) < count);
            ent_reg[i] = mem[i][W-1 -: FREG_W];
        end
    end

endmodule

// File: rtl/pa_rtu_fgpr_wb.sv
// RTU receiver for FPU FGPR writebacks; shares the write port with LSU
// FP loads, buffering FPU results while the LSU owns the port.
module pa_rtu_fgpr_wb
    import pa_rtu_fgpr_wb_pkg::*;
#(
    parameter int FLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst,
    input  logic                fpu_rtu_fgpr_wb_vld,
    input  logic [FREG_W-1:0]   fpu_rtu_fgpr_wb_reg,
    input  logic [FLEN-1:0]     fpu_rtu_fgpr_wb_data,
    output logic                rtu_fpu_fgpr_wb_grant,
    input  logic                lsu_rtu_fgpr_wb_vld,
    input  logic [FREG_W-1:0]   lsu_rtu_fgpr_wb_reg,
    input  logic [FLEN-1:0]     lsu_rtu_fgpr_wb_data,
    output logic                rtu_fgpr_wen,
    output logic [FREG_W-1:0]   rtu_fgpr_waddr,
    output logic [FLEN-1:0]     rtu_fgpr_wdata,
    output logic [FGPR_NUM-1:0] rtu_idu_fgpr_pend,
    output logic                rtu_fpu_buf_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        freg_t           rd;
        logic [FLEN-1:0] data;
    } ent_t;

    ent_t                          push_ent;
    ent_t                          head;
    logic                          push;
    logic                          pop;
    logic                          bypass;
    logic                          fpu_xfer;
    logic [PW-1:0]                 head_idx;
    logic [CW-1:0]                 count;
    logic [DEPTH-1:0]              ent_vld;
    logic [DEPTH-1:0][FREG_W-1:0]  ent_reg;

    pa_rtu_fgpr_wb_fifo #(
        .W     ($bits(ent_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (forever_cpuclk),
        .rst       (cpurst),
        .push      (push),
        .push_data (push_ent),
        .pop       (pop),
        .head      (head),
        .head_idx  (head_idx),
        .count     (count),
        .ent_vld   (ent_vld),
        .ent_reg   (ent_reg)
    );

    // Grant depends only on registered occupancy.
    assign rtu_fpu_fgpr_wb_grant = (count != CW'(DEPTH));
    assign rtu_fpu_buf_empty     = (count == '0);
    assign fpu_xfer = fpu_rtu_fgpr_wb_vld & rtu_fpu_fgpr_wb_grant;
    assign push_ent = '{rd: fpu_rtu_fgpr_wb_reg, data: fpu_rtu_fgpr_wb_data};
    assign push     = fpu_xfer & ~bypass & ~cpurst;

    always_comb begin
        rtu_fgpr_wen   = 1'b0;
        rtu_fgpr_waddr = '0;
        rtu_fgpr_wdata = '0;
        pop            = 1'b0;
        bypass         = 1'b0;
        if (!cpurst) begin
            if (lsu_rtu_fgpr_wb_vld) begin
                rtu_fgpr_wen   = 1'b1;
                rtu_fgpr_waddr = lsu_rtu_fgpr_wb_reg;
                rtu_fgpr_wdata = lsu_rtu_fgpr_wb_data;
            end else if (count != '0) begin
                rtu_fgpr_wen   = 1'b1;
                rtu_fgpr_waddr = head.rd;
                rtu_fgpr_wdata = head.data;
                pop            = 1'b1;
            end else if (fpu_xfer) begin
                rtu_fgpr_wen   = 1'b1;
                rtu_fgpr_waddr = fpu_rtu_fgpr_wb_reg;
                rtu_fgpr_wdata = fpu_rtu_fgpr_wb_data;
                bypass         = 1'b1;
            end
        end
    end

    // Entry being enqueued counts as pending; the one retiring does not.
    always_comb begin
        rtu_idu_fgpr_pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && !(pop && (PW'(i) == head_idx))) begin
                rtu_idu_fgpr_pend = rtu_idu_fgpr_pend | reg_onehot(ent_reg[i]);
            end
        end
        if (push) begin
            rtu_idu_fgpr_pend = rtu_idu_fgpr_pend | reg_onehot(fpu_rtu_fgpr_wb_reg);
        end
    end

    lsu_no_waw: assert property (
        @(posedge forever_cpuclk) disable iff (cpurst)
        lsu_rtu_fgpr_wb_vld |-> !rtu_idu_fgpr_pend[lsu_rtu_fgpr_wb_reg]
    );

endmodule

// File: tb/tb_pa_rtu_fgpr_wb.sv
// Directed bench for pa_rtu_fgpr_wb: expected FGPR writes go into a
// scoreboard queue that a negedge monitor drains against the write port.
module tb_pa_rtu_fgpr_wb;
    import pa_rtu_fgpr_wb_pkg::*;

    logic                clk;
    logic                rst;
    logic                fvld;
    logic [4:0]          freg;
    logic [31:0]         fdata;
    logic                grant;
    logic                lvld;
    logic [4:0]          lreg;
    logic [31:0]         ldata;
    logic                wen;
    logic [4:0]          waddr;
    logic [31:0]         wdata;
    logic [31:0]         pend;
    logic                empty;

    int checks = 0;
    int fails  = 0;

    fgpr_wb_t expq[$];

    pa_rtu_fgpr_wb #(.FLEN(32), .DEPTH(2)) dut (
        .forever_cpuclk        (clk),
        .cpurst                (rst),
        .fpu_rtu_fgpr_wb_vld   (fvld),
        .fpu_rtu_fgpr_wb_reg   (freg),
        .fpu_rtu_fgpr_wb_data  (fdata),
        .rtu_fpu_fgpr_wb_grant (grant),
        .lsu_rtu_fgpr_wb_vld   (lvld),
        .lsu_rtu_fgpr_wb_reg   (lreg),
        .lsu_rtu_fgpr_wb_data  (ldata),
        .rtu_fgpr_wen          (wen),
        .rtu_fgpr_waddr        (waddr),
        .rtu_fgpr_wdata        (wdata),
        .rtu_idu_fgpr_pend     (pend),
        .rtu_fpu_buf_empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ld_val(input int r);
        return 32'hA000_0000 | 32'(r);
    endfunction

    function automatic logic [31:0] fp_val(input int r);
        return 32'hF000_0000 | 32'(r);
    endfunction

    function automatic logic [31:0] bit_of(input int r);
        return 32'h1 << r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic lv, input int lr, input logic fv, input int fr);
        lvld  = lv;
        lreg  = 5'(lr);
        ldata = lv ? ld_val(lr) : 32'h0;
        fvld  = fv;
        freg  = 5'(fr);
        fdata = fv ? fp_val(fr) : 32'h0;
    endtask

    task automatic exp_wr(input int r, input logic [31:0] d);
        fgpr_wb_t e;
        e.rd   = 5'(r);
        e.data = d;
        expq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every FGPR write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wen) begin
            checks++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got reg %0d data %h expected no write at %0t",
                         waddr, wdata, $time);
            end else begin
                fgpr_wb_t e;
                e = expq.pop_front();
                if (waddr !== e.rd || wdata !== e.data) begin
                    fails++;
                    $display("FAIL wr_order: got reg %0d data %h expected reg %0d data %h at %0t",
                             waddr, wdata, e.rd, e.data, $time);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        drv(1'b0, 0, 1'b0, 0);
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd1);
        chk("rst_wen", 32'(wen), 32'd0);
        chk("rst_pend", pend, 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        tick();

        // Bypass: idle port and empty buffer
        lvld = 1'b0;
        fvld = 1'b1;
        freg = 5'd3;
        fdata = 32'h3F80_0000;
        exp_wr(3, 32'h3F80_0000);
        @(negedge clk);
        chk("byp_pend", pend, 32'd0);
        chk("byp_empty", 32'(empty), 32'd1);
        tick();
        drv(1'b0, 0, 1'b0, 0);
        @(negedge clk);
        chk("byp_empty_after", 32'(empty), 32'd1);
        tick();

        // LSU and FPU collide: FPU is buffered
        drv(1'b1, 1, 1'b1, 7);
        exp_wr(1, ld_val(1));
        exp_wr(7, fp_val(7));
        @(negedge clk);
        chk("col_pend", pend, bit_of(7));
        chk("col_grant", 32'(grant), 32'd1);
        tick();
        drv(1'b0, 0, 1'b0, 0);
        @(negedge clk);
        chk("col_pend_pop", pend, 32'd0);
        chk("col_not_empty", 32'(empty), 32'd0);
        tick();
        @(negedge clk);
        chk("col_empty", 32'(empty), 32'd1);
        tick();

        // LSU streams for 4 cycles while FPU issues 4,5,6
        for (int r = 10; r <= 13; r++) exp_wr(r, ld_val(r));
        for (int r = 4; r <= 6; r++) exp_wr(r, fp_val(r));
        drv(1'b1, 10, 1'b1, 4);
        @(negedge clk);
        chk("st_pend1", pend, bit_of(4));
        tick();
        drv(1'b1, 11, 1'b1, 5);
        @(negedge clk);
        chk("st_grant2", 32'(grant), 32'd1);
        chk("st_pend2", pend, bit_of(4) | bit_of(5));
        tick();
        drv(1'b1, 12, 1'b1, 6);
        @(negedge clk);
        chk("st_grant3", 32'(grant), 32'd0);
        chk("st_pend3", pend, bit_of(4) | bit_of(5));
        tick();
        drv(1'b1, 13, 1'b1, 6);
        @(negedge clk);
        chk("st_grant4", 32'(grant), 32'd0);
        tick();
        drv(1'b0, 0, 1'b1, 6);
        @(negedge clk);
        chk("st_grant5", 32'(grant), 32'd0);
        chk("st_pend5", pend, bit_of(5));
        tick();
        @(negedge clk);
        chk("st_grant6", 32'(grant), 32'd1);
        chk("st_pend6", pend, bit_of(6));
        tick();
        drv(1'b0, 0, 1'b0, 0);
        @(negedge clk);
        chk("st_pend7", pend, 32'd0);
        tick();
        @(negedge clk);
        chk("st_empty", 32'(empty), 32'd1);
        tick();

        // Full buffer drains with LSU idle; both pointers wrap 1->0
        exp_wr(20, ld_val(20));
        exp_wr(21, ld_val(21));
        exp_wr(14, fp_val(14));
        exp_wr(15, fp_val(15));
        exp_wr(9, fp_val(9));
        drv(1'b1, 20, 1'b1, 14);
        tick();
        drv(1'b1, 21, 1'b1, 15);
        @(negedge clk);
        chk("full_pend", pend, bit_of(14) | bit_of(15));
        tick();
        drv(1'b0, 0, 1'b1, 9);
        @(negedge clk);
        chk("full_grant0", 32'(grant), 32'd0);
        chk("full_pend_pop", pend, bit_of(15));
        tick();
        @(negedge clk);
        chk("full_grant1", 32'(grant), 32'd1);
        chk("full_pend_wrap", pend, bit_of(9));
        tick();
        drv(1'b0, 0, 1'b0, 0);
        @(negedge clk);
        chk("full_pend_last", pend, 32'd0);
        tick();
        @(negedge clk);
        chk("full_empty", 32'(empty), 32'd1);
        tick();

        // Reset with two buffered entries discards them
        exp_wr(22, ld_val(22));
        exp_wr(23, ld_val(23));
        drv(1'b1, 22, 1'b1, 16);
        tick();
        drv(1'b1, 23, 1'b1, 17);
        tick();
        drv(1'b0, 0, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_wen", 32'(wen), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_grant", 32'(grant), 32'd1);
        chk("mrst_pend", pend, 32'd0);
        chk("mrst_empty", 32'(empty), 32'd1);
        chk("mrst_wen_after", 32'(wen), 32'd0);
        repeat (4) tick();

        chk("sb_drained", 32'(expq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
